sync_word_capture: RTL
======================

SYNC_WORD_CAPTURE -- requirements
Module: sync_word_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 10, bit width of the synchronized word.
REQ-002 SHALL have parameter STABLE_CYCLES, default 3, consecutive equal samples required before a word is accepted; legal range 1..15.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port D  input  WIDTH  word from the upstream multi-bit clock synchronizer output, possibly bit-skewed.
REQ-006 SHALL have port Q  output  WIDTH  accepted word presented to the consumer.
REQ-007 SHALL have port valid  output  1  Q holds an unconsumed accepted word.
REQ-008 SHALL have port ready  input  1  consumer takes Q at an edge where valid=1 and ready=1.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: an unconsumed word was overwritten.

Function
REQ-010 SHALL register D every edge into sample; run counter runLen (saturating at STABLE_CYCLES) counts consecutive edges with D equal to sample.
REQ-011 SHALL set runLen to 1 at an edge where D differs from sample, else increment runLen, saturating at STABLE_CYCLES.
REQ-012 SHALL declare acceptance at the edge where runLen becomes STABLE_CYCLES (STABLE_CYCLES=1: every edge where D differs from sample) and D differs from committed.
REQ-013 SHALL, on acceptance, load Q and committed with D and set valid=1 after that edge.
REQ-014 SHALL give latency: D changes before edge k and holds -> valid=1 after edge k+STABLE_CYCLES-1 (STABLE_CYCLES=3: third edge).
REQ-015 SHALL NOT accept a word equal to committed; a glitch returning to the committed value produces no valid.
REQ-016 SHALL NOT accept any word whose run is interrupted before STABLE_CYCLES equal samples; runLen restarts at 1.
REQ-017 SHALL hold Q constant while valid=1 and no acceptance occurs.
REQ-018 SHALL clear valid after an edge with valid=1, ready=1 and no acceptance.
REQ-019 SHALL, on acceptance at an edge with valid=1 and ready=0, overwrite Q, keep valid=1, and pulse overrun=1 for exactly one cycle.
REQ-020 SHALL, on acceptance at an edge with valid=1 and ready=1, load the new word, keep valid=1, overrun=0.
REQ-021 SHALL ignore ready while valid=0.
REQ-022 SHALL keep runLen saturated while D stays constant; no repeated acceptance.

Reset
REQ-023 SHALL, at an edge with reset=1, clear Q, valid, overrun, sample, committed, runLen to 0, regardless of state.
REQ-024 SHALL, after reset, treat D=0 as committed: holding D=0 produces no valid.
REQ-025 SHALL discard a pending word on reset mid-operation; no overrun pulse.

Structure
REQ-026 SHALL implement the run counter as sub-module stability_counter (inputs clock, reset, equal; output runLen; parameter STABLE_CYCLES).
REQ-027 SHALL place default WIDTH and STABLE_CYCLES constants in the shared jtag_interface constants file; no typedefs required.
REQ-028 SHALL size runLen as the minimum bits to hold STABLE_CYCLES.

Verification
REQ-029 SHALL cover: reset then D=0 for 20 cycles -> valid stays 0, overrun 0.
REQ-030 SHALL cover: D 0->10'h3FF held, ready=0 -> valid=1 with Q=10'h3FF after third edge, Q held until ready=1, valid=0 one edge later.
REQ-031 SHALL cover: D=10'h155 for 2 edges then 10'h0AA held -> 10'h155 never accepted; 10'h0AA accepted 3 edges after its change.
REQ-032 SHALL cover: 10'h1FF accepted, ready=0, then 10'h0F0 held 3 edges -> Q=10'h0F0, valid=1, overrun=1 for one cycle.
REQ-033 SHALL cover: 10'h1FF accepted and consumed, D glitches to 10'h100 for 1 edge and back -> no new valid.
REQ-034 SHALL cover: reset asserted with valid=1 -> next edge Q=0, valid=0, overrun=0; STABLE_CYCLES=1 build accepts each change after one edge.

Source files
------------

// File: rtl/jtag_interface_pkg.sv
// rtl/jtag_interface_pkg.sv - shared interface constants for the word capture block
package jtag_interface_pkg;

  localparam int SWC_WIDTH_DEFAULT         = 10;
  localparam int SWC_STABLE_CYCLES_DEFAULT = 3;

  // Output holding slot: empty until a word is accepted, full until consumed.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/stability_counter.sv
// rtl/stability_counter.sv - saturating count of consecutive equal samples
module stability_counter
  import jtag_interface_pkg::*;
#(
  parameter int STABLE_CYCLES = SWC_STABLE_CYCLES_DEFAULT,
  localparam int RUN_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             equal,
  output logic [RUN_W-1:0] runLen
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  always_ff @(posedge clock) begin
    if (reset) begin
      runLen <= '0;
    end else if (!equal) begin
      runLen <= RUN_W'(1);
    end else if (runLen != RUN_MAX) begin
      runLen <= runLen + RUN_W'(1);
    end
  end

endmodule

// File: rtl/sync_word_capture.sv
// rtl/sync_word_capture.sv - accepts a synchronized word once it has been stable long enough
module sync_word_capture
  import jtag_interface_pkg::*;
#(
  parameter int WIDTH         = SWC_WIDTH_DEFAULT,
  parameter int STABLE_CYCLES = SWC_STABLE_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);

  localparam int               RUN_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(STABLE_CYCLES - 1);
  localparam bit               SINGLE  = (STABLE_CYCLES == 1);

  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] committed;
  logic [RUN_W-1:0] runLen;
  logic             equal;
  logic             run_arrives;
  logic             accept;
  slot_state_t      state;
  slot_state_t      state_next;

  assign equal = (D == sample);

  stability_counter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stability_counter (
    .clock (clock),
    .reset (reset),
    .equal (equal),
    .runLen(runLen)
  );

  // The run reaches its threshold only on the transition into saturation,
  // so a word held indefinitely is offered exactly once.
  assign run_arrives = equal ? (runLen == RUN_PRE) : SINGLE;
  assign accept      = run_arrives && (D != committed);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: if (accept) state_next = SLOT_FULL;
      SLOT_FULL:  if (!accept && ready) state_next = SLOT_EMPTY;
    endcase
  end

  assign valid = (state == SLOT_FULL);

  always_ff @(posedge clock) begin
    if (reset) begin
      sample    <= '0;
      committed <= '0;
      Q         <= '0;
      overrun   <= 1'b0;
    end else begin
      sample  <= D;
      overrun <= accept && valid && !ready;
      if (accept) begin
        committed <= D;
        Q         <= D;
      end
    end
  end

endmodule
